// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector and its bit counter:
// multiplexer code width, function codes, FSM state encoding and a
// reduction helper used by the optional parity output (RESULT_PARITY_EN).
package result_collector_pkg;

  // Width of the multiplexer function code.
  localparam int MUX_WIDTH = 3;

  // Function codes selected by the multiplexer.
  typedef enum logic [MUX_WIDTH-1:0] {
    FN_AND        = 3'b000,
    FN_OR         = 3'b001,
    FN_XOR        = 3'b010,
    FN_ADDER      = 3'b011,
    FN_SUBTRACTOR = 3'b100
  } fn_e;

  // Collector FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  // Even parity (XOR of all bits) of an assembled word.
  function automatic logic word_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/result_collector_bit_counter.sv
// Saturating bit counter: synchronous clear, count enable and a
// terminal-count flag at WIDTH-1. Shared with the operand serializer.
module result_collector_bit_counter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 tc_o
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WIDTH - 1);

  assign tc_o = (count_o == LAST);

  // Count accepted bits; clear wins over enable, and the count stops at LAST.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (en_i && !tc_o) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Result collector: assembles the LSB-first serial result stream into a
// DATA_WIDTH-bit word, tags it with the function code latched at start,
// flags a zero result and hands the word off over valid/ready.
// Optional parity output is enabled by defining RESULT_PARITY_EN.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [MUX_WIDTH-1:0]  f_i,
  input  logic                  bit_valid_i,
  input  logic                  result_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [MUX_WIDTH-1:0]  op_o,
  output logic                  zero_o
`ifdef RESULT_PARITY_EN
  ,
  output logic                  parity_o
`endif
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

  state_e                state;
  logic [DATA_WIDTH-2:0] shreg;
  logic [MUX_WIDTH-1:0]  op_q;
  logic [DATA_WIDTH-1:0] shift_word;
  logic [CNT_WIDTH-1:0]  bit_count;
  logic                  last_bit;
  logic                  count_clear;
  logic                  count_en;

  // Word as it would look with the current bit shifted in. The previous
  // DATA_WIDTH-1 bits live in shreg, so after the final bit this is the
  // complete result with the first accepted bit at position 0.
  assign shift_word = {result_i, shreg};

  // A start outside HOLD clears the count; bits count only while shifting.
  assign count_clear = start_i && (state != ST_HOLD);
  assign count_en    = (state == ST_SHIFT) && bit_valid_i && !start_i;

  result_collector_bit_counter #(
    .WIDTH     (DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bit_counter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (count_clear),
    .en_i    (count_en),
    .count_o (bit_count),
    .tc_o    (last_bit)
  );

  // Collector FSM with registered handshake, data and flag outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the shift register is reset too, so an aborted partial word
      // can never leak into a later result.
      state   <= ST_IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      op_o    <= '0;
      zero_o  <= 1'b0;
      shreg   <= '0;
      op_q    <= '0;
`ifdef RESULT_PARITY_EN
      parity_o <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // Bits arriving in IDLE, even alongside start, are dropped.
          if (start_i) begin
            state  <= ST_SHIFT;
            busy_o <= 1'b1;
            shreg  <= '0;
            op_q   <= f_i;
          end
        end

        ST_SHIFT: begin
          if (start_i) begin
            // Abort and restart: the bit presented this cycle is discarded.
            shreg <= '0;
            op_q  <= f_i;
          end else if (bit_valid_i) begin
            shreg <= shift_word[DATA_WIDTH-1:1];
            if (last_bit) begin
              state   <= ST_HOLD;
              busy_o  <= 1'b0;
              valid_o <= 1'b1;
              data_o  <= shift_word;
              op_o    <= op_q;
              zero_o  <= ~|shift_word;
`ifdef RESULT_PARITY_EN
              parity_o <= word_parity(64'(shift_word));
`endif
            end
          end
        end

        ST_HOLD: begin
          // Outputs stay frozen until the consumer takes the word.
          if (ready_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector (DATA_WIDTH = 8). Expected
// values come from the word the bench itself serializes: bit k of the
// result is the k-th bit it presented with bit_valid_i high.
// Parity checks are compiled in when RESULT_PARITY_EN is defined.
module tb_result_collector;

  localparam int W = 8;

  logic         clk_i;
  logic         rst_n_i;
  logic         start_i;
  logic [2:0]   f_i;
  logic         bit_valid_i;
  logic         result_i;
  logic         ready_i;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic [2:0]   op_o;
  logic         zero_o;
`ifdef RESULT_PARITY_EN
  logic         parity_o;
`endif

  int tests_run;
  int tests_failed;

  result_collector #(.DATA_WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .f_i         (f_i),
    .bit_valid_i (bit_valid_i),
    .result_i    (result_i),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .op_o        (op_o),
    .zero_o      (zero_o)
`ifdef RESULT_PARITY_EN
    ,
    .parity_o    (parity_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Everything a consumer should see while a finished word is offered.
  task automatic check_hold(input string tag, input logic [7:0] word, input logic [2:0] f);
    check1({tag, "_valid"}, valid_o, 1'b1);
    check1({tag, "_busy"}, busy_o, 1'b0);
    check8({tag, "_data"}, data_o, word);
    check8({tag, "_op"}, 8'(op_o), 8'(f));
    check1({tag, "_zero"}, zero_o, (word == 8'h00));
`ifdef RESULT_PARITY_EN
    check1({tag, "_parity"}, parity_o, ^word);
`endif
  endtask

  // Present one bit, optionally preceded by random idle gaps.
  task automatic send_bit(input logic b, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) begin
      bit_valid_i = 1'b0;
      result_i    = 1'($urandom);
      tick();
      check1("gap_busy", busy_o, 1'b1);
    end
    bit_valid_i = 1'b1;
    result_i    = b;
    tick();
    bit_valid_i = 1'b0;
  endtask

  // Serialize 'word' LSB first after a start carrying f; check that busy
  // holds through the stream and valid rises one cycle after the last bit.
  task automatic send_word(input logic [7:0] word, input logic [2:0] f, input int gap_pct);
    for (int k = 0; k < W; k++) begin
      send_bit(word[k], gap_pct);
      if (k < W - 1) begin
        check1("shift_busy", busy_o, 1'b1);
        check1("shift_valid", valid_o, 1'b0);
      end
    end
    check_hold("done", word, f);
  endtask

  // Hold with backpressure and stray inputs, then complete the handshake.
  task automatic drain(input logic [7:0] word, input logic [2:0] f, input int hold_cycles);
    for (int h = 0; h < hold_cycles; h++) begin
      ready_i     = 1'b0;
      start_i     = 1'($urandom);
      bit_valid_i = 1'($urandom);
      result_i    = 1'($urandom);
      f_i         = 3'($urandom);
      tick();
      check_hold("hold", word, f);
    end
    start_i     = 1'b0;
    bit_valid_i = 1'b0;
    ready_i     = 1'b1;
    tick();
    ready_i = 1'b0;
    check1("ack_valid", valid_o, 1'b0);
    check1("ack_busy", busy_o, 1'b0);
    check8("ack_data", data_o, word);
    check8("ack_op", 8'(op_o), 8'(f));
    tick();
    check1("idle_valid", valid_o, 1'b0);
    check1("idle_busy", busy_o, 1'b0);
  endtask

  // Start an operation; a bit offered with the start must be ignored.
  task automatic do_start(input logic [2:0] f, input logic stray_bit);
    start_i     = 1'b1;
    f_i         = f;
    bit_valid_i = stray_bit;
    result_i    = 1'($urandom);
    tick();
    start_i     = 1'b0;
    bit_valid_i = 1'b0;
    f_i         = 3'($urandom);
    check1("start_busy", busy_o, 1'b1);
    check1("start_valid", valid_o, 1'b0);
  endtask

  task automatic run_op(input logic [7:0] word, input logic [2:0] f,
                        input int gap_pct, input int hold_cycles, input logic stray_bit);
    do_start(f, stray_bit);
    send_word(word, f, gap_pct);
    drain(word, f, hold_cycles);
  endtask

  // Watchdog: the bench never waits on the DUT, but guard against hangs.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    logic [2:0] f;
    tests_run    = 0;
    tests_failed = 0;
    rst_n_i      = 1'b0;
    start_i      = 1'b0;
    f_i          = 3'b000;
    bit_valid_i  = 1'b0;
    result_i     = 1'b0;
    ready_i      = 1'b0;

    // Reset state.
    repeat (2) tick();
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_valid", valid_o, 1'b0);
    check8("rst_data", data_o, 8'h00);
    check8("rst_op", 8'(op_o), 8'h00);
    check1("rst_zero", zero_o, 1'b0);
    rst_n_i = 1'b1;
    tick();

    // Basic capture: 1,0,1,0,0,0,0,1 LSB first -> 0x85 tagged ADDER.
    run_op(8'h85, 3'b011, 0, 0, 1'b0);

    // Gaps and backpressure with stray start/bit pulses during HOLD.
    do_start(3'b011, 1'b0);
    send_bit(1'b1, 0);
    bit_valid_i = 1'b0; tick();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    bit_valid_i = 1'b0; tick();
    check1("gap5_busy", busy_o, 1'b1);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    check_hold("gaps", 8'h85, 3'b011);
    drain(8'h85, 3'b011, 4);

    // Zero flag with SUBTRACTOR code.
    run_op(8'h00, 3'b100, 0, 1, 1'b1);

    // Abort: four ones, restart with XOR while a bit is presented, then 0xF0.
    do_start(3'b000, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 0);
    start_i     = 1'b1;
    f_i         = 3'b010;
    bit_valid_i = 1'b1;
    result_i    = 1'b1;
    tick();
    start_i     = 1'b0;
    bit_valid_i = 1'b0;
    check1("abort_busy", busy_o, 1'b1);
    check1("abort_valid", valid_o, 1'b0);
    send_word(8'hF0, 3'b010, 0);
    drain(8'hF0, 3'b010, 1);

    // Parity reference word with even parity.
    run_op(8'h03, 3'b001, 0, 0, 1'b0);

    // Asynchronous reset mid-operation after three bits.
    do_start(3'b001, 1'b0);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 0);
    #2;
    rst_n_i = 1'b0;
    #1;
    check1("amid_busy", busy_o, 1'b0);
    check1("amid_valid", valid_o, 1'b0);
    check8("amid_data", data_o, 8'h00);
    check8("amid_op", 8'(op_o), 8'h00);
    check1("amid_zero", zero_o, 1'b0);
`ifdef RESULT_PARITY_EN
    check1("amid_parity", parity_o, 1'b0);
`endif
    tick();
    rst_n_i = 1'b1;
    tick();
    // A full fresh 8-bit capture must be needed after the reset.
    run_op(8'hA5, 3'b010, 0, 0, 1'b0);

    // Randomized operations with gaps, stray bits and backpressure.
    for (int n = 0; n < 30; n++) begin
      w = 8'($urandom);
      if ($urandom_range(0, 7) == 0) w = 8'h00;
      f = 3'($urandom_range(0, 4));
      run_op(w, f, 25, $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
